// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling from a half-bit
// offset after the start edge, registered byte/valid/framing-error/busy outputs.
module uart_rx #(
  parameter int unsigned CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       framing_error_o,
  output logic       busy_o
);

  localparam int unsigned CntW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  logic            sync1_q;
  logic            sync2_q;
  logic            rx_prev_q;
  logic [1:0]      arm_q;
  logic            rx_s;
  logic            start_edge;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            ferr_q;
  logic            busy_q;

  // Synchronizer plus edge history; arm_q blocks edges until the flops hold real line
  // samples, so a line that is low at reset release does not look like a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      arm_q     <= 2'd0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
      if (arm_q != 2'd3) begin
        arm_q <= arm_q + 2'd1;
      end
    end
  end

  assign rx_s       = sync2_q;
  assign start_edge = (arm_q == 2'd3) && rx_prev_q && !rx_s;

  // Frame FSM; pulses default low every cycle so they last exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            cnt_q   <= HalfLoad;
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (rx_s) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q   <= FullLoad;
              idx_q   <= 3'd0;
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            shift_q[idx_q] <= rx_s;
            cnt_q          <= FullLoad;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == '0) begin
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o          = data_q;
  assign valid_o         = valid_q;
  assign framing_error_o = ferr_q;
  assign busy_o          = busy_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset (0 = reset), sampled on clk.
REQ-004 SHALL have port rx  input  1  asynchronous serial line from host; idles high.
REQ-005 SHALL have port data_o  output  8  last correctly received byte.
REQ-006 SHALL have port valid_o  output  1  one-cycle pulse: data_o holds a new byte.
REQ-007 SHALL have port framing_error_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer, with both flops resetting to 1; all decisions use the synchronized value rx_s.
REQ-010 SHALL detect a start edge as rx_s=0 in a cycle whose previous rx_s was 1 (falling edge), and only in IDLE.
REQ-011 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH, with a baud counter of width clog2(CLOCKS_PER_BAUD) and a 3-bit bit index.
REQ-012 IDLE: on a start edge, SHALL load the counter with CLOCKS_PER_BAUD/2 - 1 (integer division) and go to START.
REQ-013 START: SHALL decrement the counter each cycle; at 0, sample rx_s. If 1, treat it as a glitch and return to IDLE with no output pulse. If 0, load the counter with CLOCKS_PER_BAUD-1, clear the bit index, and go to DATA.
REQ-014 DATA: at counter 0, SHALL shift rx_s into bit[index] (LSB first) and reload CLOCKS_PER_BAUD-1. At index 7, go to STOP; otherwise increment the index.
REQ-015 STOP: at counter 0, SHALL sample rx_s. If 1, update data_o with the shift register, pulse valid_o for exactly the next cycle, and go to IDLE. If 0, pulse framing_error_o for exactly the next cycle, leave data_o unchanged, and go to WAIT_HIGH.
REQ-016 WAIT_HIGH: SHALL remain until rx_s=1, then go to IDLE. A line held low (break) SHALL produce exactly one framing_error_o pulse and no further frames.
REQ-017 valid_o and framing_error_o SHALL never both be high, and SHALL never be high for two consecutive cycles.
REQ-018 Latency: the valid_o rising edge SHALL occur 1 cycle after the stop-bit sample, which falls CLOCKS_PER_BAUD/2 + 9*CLOCKS_PER_BAUD cycles after the start edge is seen on rx_s.
REQ-019 A start edge arriving in the same cycle as the return to IDLE SHALL NOT be detected; detection needs IDLE plus a falling edge in a later cycle. The cost is at most 1 cycle of skew, which stays inside the half-bit margin.
REQ-020 rx activity outside IDLE SHALL NOT restart frame reception; only state timing governs sampling.
REQ-021 data_o SHALL hold its value between frames; there is no flow control, and an unconsumed byte is overwritten by the next valid frame.

Reset
REQ-022 While rst=0 on a clk edge, the block SHALL enter IDLE with data_o=8'h00, valid_o=0, framing_error_o=0, busy_o=0, counter=0, bit index=0, and synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no output pulse. After rst returns to 1, the block SHALL ignore the rest of that frame until a new falling edge occurs in IDLE. A frame already in progress with the line low at release SHALL NOT be decoded.
REQ-024 Outputs SHALL be valid in the first cycle after rst deasserts.

Verification (CLOCKS_PER_BAUD=8 unless stated)
REQ-025 Send byte 8'hA5 with a correct stop bit -> exactly one valid_o pulse with data_o=8'hA5 and no framing_error_o, on the cycle given by REQ-018 (+2 synchronizer cycles from the rx pin edge).
REQ-026 Send 8'h00, then 8'hFF back-to-back with no idle gap -> two valid_o pulses carrying 8'h00 and then 8'hFF; busy_o falls between the frames for at least 1 cycle.
REQ-027 Drive rx low for 3 cycles, then high -> no valid_o, no framing_error_o, busy_o back to 0 after the START sample.
REQ-028 Send 8'h3C with the stop bit low, then hold rx low for 40 cycles, then release -> one framing_error_o pulse, data_o keeps its previous value, and the next 8'h81 frame is received correctly.
REQ-029 Assert rst=0 for 1 cycle during bit 4 of a frame -> no pulses for that frame, all outputs at reset values, and the next clean frame 8'h5A is received.
REQ-030 With the default CLOCKS_PER_BAUD=868, send 8'h55 with the host baud period at 866 and at 870 cycles -> both are received correctly.
